pong_state_reader: RTL and testbench

Host-side reader for the pong engine's multiplexed state bus. It generates the engine's game-tick strobe and 2-bit field select, captures the four 8-bit state fields (ball x, ball y, left paddle y, right paddle y) from the engine's registered output byte, and publishes them as one frame. Frames go to a downstream renderer over a valid/ready handshake. It sits between the engine pins (`clk2`, `output_select`, `uo_out`) and the display logic.

---
 rtl/pong_state_reader.sv | 115 +++++++++++
 tb/tb_pong_state_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_state_reader.sv
// Host-side reader for the pong engine's multiplexed state bus: drives the
// game tick and field select, captures four fields and publishes them as a frame.
module pong_state_reader #(
  parameter int TICK_DIV = 4,
  parameter int SETTLE   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        tick_out,
  output logic [1:0]  sel_out,
  input  logic [7:0]  data_in,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [7:0]  ball_x,
  output logic [7:0]  ball_y,
  output logic [7:0]  left_y,
  output logic [7:0]  right_y,
  output logic [15:0] frame_count,
  output logic        overrun
);

  localparam int SLOT = 2 * TICK_DIV;
  localparam int PW   = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SLOT - 1);
  localparam logic [PW-1:0] P_TICK = PW'(TICK_DIV);
  localparam logic [PW-1:0] P_CAP  = PW'(TICK_DIV + SETTLE - 1);

  typedef enum logic {IDLE, ACQ} state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] phase, nxt_phase;
  logic [1:0]    field, nxt_field;
  logic [7:0]    stage [4];
  logic          pend;

  // run is only looked at in IDLE and on the last clock of slot 3
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_field = field;
    case (state)
      IDLE: begin
        if (run) begin
          nxt_state = ACQ;
          nxt_phase = '0;
          nxt_field = 2'd0;
        end
      end
      ACQ: begin
        if (phase == P_LAST) begin
          nxt_phase = '0;
          if (field == 2'd3) begin
            nxt_field = 2'd0;
            if (!run) nxt_state = IDLE;
          end else begin
            nxt_field = field + 2'd1;
          end
        end else begin
          nxt_phase = phase + PW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      field       <= 2'd0;
      tick_out    <= 1'b0;
      sel_out     <= 2'd0;
      pend        <= 1'b0;
      frame_valid <= 1'b0;
      ball_x      <= 8'd0;
      ball_y      <= 8'd0;
      left_y      <= 8'd0;
      right_y     <= 8'd0;
      frame_count <= 16'd0;
      overrun     <= 1'b0;
      for (int i = 0; i < 4; i++) stage[i] <= 8'd0;
    end else begin
      state    <= nxt_state;
      phase    <= nxt_phase;
      field    <= nxt_field;
      tick_out <= (nxt_state == ACQ) && (nxt_phase >= P_TICK);
      sel_out  <= (nxt_state == ACQ) ? nxt_field : 2'd0;

      if (pend) begin
        pend <= 1'b0;
        if (!frame_valid || frame_ready) begin
          ball_x      <= stage[0];
          ball_y      <= stage[1];
          left_y      <= stage[2];
          right_y     <= stage[3];
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      // A field-3 capture schedules the publish for the following clock
      if (state == ACQ && phase == P_CAP) begin
        stage[field] <= data_in;
        if (field == 2'd3) pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pong_state_reader.sv
// Bench for pong_state_reader: engine stand-in, frame-level reference model,
// directed scenarios and a randomized run/ready/reset soak.
module tb_pong_state_reader;

  localparam int TD   = 2;
  localparam int ST   = 1;
  localparam int SLOT = 2 * TD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        frame_ready = 1'b0;
  logic        tick_out;
  logic [1:0]  sel_out;
  logic [7:0]  data_in;
  logic        frame_valid;
  logic [7:0]  ball_x, ball_y, left_y, right_y;
  logic [15:0] frame_count;
  logic        overrun;

  int total = 0;
  int bad = 0;

  pong_state_reader #(.TICK_DIV(TD), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .run(run), .tick_out(tick_out), .sel_out(sel_out),
    .data_in(data_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .ball_x(ball_x), .ball_y(ball_y), .left_y(left_y), .right_y(right_y),
    .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Engine stand-in: each tick rise advances the game; the byte shown depends on the select
  logic [7:0] game [256][4];
  logic       fixed_mode = 1'b1;
  int         e_steps = 0;

  always @(posedge tick_out) e_steps <= e_steps + 1;
  assign data_in = fixed_mode ? 8'(({6'd0, sel_out} + 8'd1) << 4) : game[e_steps[7:0]][sel_out];

  function automatic logic [7:0] game_val(int s, int f);
    if (fixed_mode) return 8'((f + 1) * 16);
    return game[s % 256][f];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a frame is 4 slots of SLOT clocks counted from its start edge
  bit         started = 0;
  bit         m_active = 0, m_pend = 0, m_valid = 0, m_over = 0;
  int         m_cyc = 0, m_steps = 0;
  logic [15:0] m_count = 0;
  logic [7:0] m_stage [4];
  logic [7:0] m_fields [4];

  always @(posedge clk) begin
    int slot, ph;
    started = 1;
    if (reset) begin
      m_active = 0; m_pend = 0; m_valid = 0; m_over = 0; m_cyc = 0; m_count = 0;
      for (int i = 0; i < 4; i++) begin m_stage[i] = 0; m_fields[i] = 0; end
    end else begin
      if (m_pend) begin
        if (!m_valid || frame_ready) begin
          m_fields = m_stage;
          m_valid = 1;
          m_count++;
        end else begin
          m_over = 1;
        end
        m_pend = 0;
      end else if (m_valid && frame_ready) begin
        m_valid = 0;
      end
      if (m_active) begin
        slot = m_cyc / SLOT;
        ph   = m_cyc % SLOT;
        if (ph == TD + ST - 1) begin
          m_stage[slot] = game_val(m_steps, slot);
          if (slot == 3) m_pend = 1;
        end
        if (m_cyc == 4 * SLOT - 1) begin
          if (run) m_cyc = 0;
          else m_active = 0;
        end else begin
          m_cyc++;
        end
        if (m_active && (m_cyc % SLOT) == TD) m_steps++;
      end else if (run) begin
        m_active = 1;
        m_cyc = 0;
      end
    end
  end

  // Every output against the model on each falling edge
  always @(negedge clk) begin
    if (started) begin
      checkOutput("tick_out", {15'd0, tick_out}, {15'd0, m_active && (m_cyc % SLOT) >= TD});
      checkOutput("sel_out", {14'd0, sel_out}, m_active ? 16'(m_cyc / SLOT) : 16'd0);
      checkOutput("frame_valid", {15'd0, frame_valid}, {15'd0, m_valid});
      checkOutput("ball_x", {8'd0, ball_x}, {8'd0, m_fields[0]});
      checkOutput("ball_y", {8'd0, ball_y}, {8'd0, m_fields[1]});
      checkOutput("left_y", {8'd0, left_y}, {8'd0, m_fields[2]});
      checkOutput("right_y", {8'd0, right_y}, {8'd0, m_fields[3]});
      checkOutput("frame_count", frame_count, m_count);
      checkOutput("overrun", {15'd0, overrun}, {15'd0, m_over});
    end
  end

  task automatic applyStimulus(input logic r, input logic rd, input logic rs);
    @(posedge clk);
    #1;
    run = r;
    frame_ready = rd;
    reset = rs;
  endtask

  initial begin
    int lat, tick_hits;
    logic [15:0] pat;
    for (int s = 0; s < 256; s++)
      for (int f = 0; f < 4; f++) game[s][f] = 8'($urandom);

    // Reset held, then released idle
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    tick_hits = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0);
      if (tick_out !== 1'b0) tick_hits++;
    end
    checkOutput("idle_tick_hits", 16'(tick_hits), 16'd0);
    checkOutput("rst_valid", {15'd0, frame_valid}, 16'd0);
    checkOutput("rst_sel", {14'd0, sel_out}, 16'd0);
    checkOutput("rst_count", frame_count, 16'd0);
    checkOutput("rst_fields", {ball_x, right_y}, 16'd0);

    // Single frame from a one-cycle run pulse with fixed engine bytes
    applyStimulus(1, 0, 0);
    @(posedge clk);
    #1;
    run = 0;
    pat = 16'd0;
    pat[0] = tick_out;
    lat = 0;
    while (!frame_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < 16) pat[lat] = tick_out;
    end
    checkOutput("first_latency", 16'(lat), 16'd16);
    checkOutput("tick_pattern", pat, 16'hCCCC);
    checkOutput("single_ball_x", {8'd0, ball_x}, 16'h0010);
    checkOutput("single_ball_y", {8'd0, ball_y}, 16'h0020);
    checkOutput("single_left_y", {8'd0, left_y}, 16'h0030);
    checkOutput("single_right_y", {8'd0, right_y}, 16'h0040);
    checkOutput("single_count", frame_count, 16'd1);
    repeat (4) applyStimulus(0, 0, 0);
    fixed_mode = 1'b0;

    // Continuous with accept: five publishes over 81 edges
    applyStimulus(1, 1, 0);
    repeat (81) @(posedge clk);
    #1;
    checkOutput("cont_count", frame_count, 16'd6);
    checkOutput("cont_overrun", {15'd0, overrun}, 16'd0);

    // Overrun: second frame dropped while the first is held
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("ovr_first_valid", {15'd0, frame_valid}, 16'd1);
    checkOutput("ovr_first_flag", {15'd0, overrun}, 16'd0);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("ovr_flag", {15'd0, overrun}, 16'd1);
    checkOutput("ovr_count", frame_count, 16'd1);

    // Accept on exactly the publish cycle of frame 2
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    repeat (32) @(posedge clk);
    #1;
    frame_ready = 1;
    @(posedge clk);
    #1;
    frame_ready = 0;
    checkOutput("simul_valid", {15'd0, frame_valid}, 16'd1);
    checkOutput("simul_count", frame_count, 16'd2);
    checkOutput("simul_overrun", {15'd0, overrun}, 16'd0);

    // Reset during field 2 abandons the frame
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    run = 0;
    @(posedge clk);
    #1;
    reset = 0;
    checkOutput("midrst_valid", {15'd0, frame_valid}, 16'd0);
    checkOutput("midrst_count", frame_count, 16'd0);
    run = 1;
    @(posedge clk);
    #1;
    checkOutput("midrst_restart_sel", {14'd0, sel_out}, 16'd0);
    lat = 0;
    while (!frame_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("midrst_restart_lat", 16'(lat), 16'd16);
    checkOutput("midrst_restart_count", frame_count, 16'd1);

    // Randomized soak of run, ready and occasional reset
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom % 8) != 0, 1'($urandom), ($urandom % 100) == 0);

    applyStimulus(0, 0, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
